// File: rtl/system_top_mul_pipe_rs.sv
// system_top_mul_pipe_rs: pipelined signed multiplier with round/shift/saturate, valid/ready flow control and overflow counter
// Ports: ap_clk/ap_rst_n clock and async active-low reset; in_vld/in_rdy/din0/din1 input beat;
//        out_vld/out_rdy/dout/ovf output beat; ovf_cnt saturating overflow count, ovf_clr sync clear
module system_top_mul_pipe_rs #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 27,
  parameter int dout_WIDTH = 32,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SAT        = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic [CNT_WIDTH-1:0]  ovf_cnt,
  input  logic                  ovf_clr
);
  localparam int W  = din0_WIDTH + din1_WIDTH;
  localparam int DW = dout_WIDTH;
  localparam logic signed [W:0] RND = (ROUND != 0 && SHIFT > 0) ? ((W+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  logic                 r_up;
  logic [NUM_STAGE-1:0] r_vld;
  logic [NUM_STAGE-1:0] r_ovf;
  logic [DW-1:0]        r_dat [NUM_STAGE];
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_en;
  logic                 w_acc;
  logic                 w_fit;
  logic                 w_inc;
  logic signed [W-1:0]  w_prod;
  logic signed [W:0]    w_sum;
  logic signed [W:0]    w_shr;
  logic [W-DW+1:0]      w_hi;
  logic [DW-1:0]        w_res;
  // rounding add carried one bit wider than the product so it can never wrap
  assign w_prod = $signed(din0) * $signed(din1);
  assign w_sum  = {w_prod[W-1], w_prod} + RND;
  assign w_shr  = w_sum >>> SHIFT;
  // result fits when every bit from the dout sign bit upward agrees
  assign w_hi   = w_shr[W:DW-1];
  assign w_fit  = (&w_hi) | ~(|w_hi);
  assign w_res  = (SAT != 0 && !w_fit) ? (w_shr[W] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                                       : w_shr[DW-1:0];
  // in_rdy is held low for the first cycle after reset release
  assign w_en    = ~r_vld[NUM_STAGE-1] | out_rdy;
  assign in_rdy  = w_en & r_up;
  assign w_acc   = in_vld & in_rdy;
  assign out_vld = r_vld[NUM_STAGE-1];
  assign dout    = r_dat[NUM_STAGE-1];
  assign ovf     = r_ovf[NUM_STAGE-1];
  assign ovf_cnt = r_cnt;
  assign w_inc   = out_vld & out_rdy & ovf;
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      r_up  <= 1'b0;
      r_vld <= '0;
      r_ovf <= '0;
      for (int i = 0; i < NUM_STAGE; i++) r_dat[i] <= '0;
    end else begin
      r_up <= 1'b1;
      if (w_en) begin
        r_vld[0] <= w_acc;
        r_ovf[0] <= ~w_fit;
        r_dat[0] <= w_res;
        for (int i = 1; i < NUM_STAGE; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_ovf[i] <= r_ovf[i-1];
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) r_cnt <= '0;
    else if (ovf_clr) r_cnt <= w_inc ? CNT_WIDTH'(1) : '0;
    else if (w_inc && r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
endmodule
